// File: rtl/csr_mmode_pkg.sv
// Shared definitions for the machine-mode CSR block: addresses, operation encodings,
// cause codes and mstatus field positions.
package csr_mmode_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  typedef enum logic [1:0] {
    CsrOpNone = 2'b00,
    CsrOpRw   = 2'b01,
    CsrOpRs   = 2'b10,
    CsrOpRc   = 2'b11
  } csr_op_e;

  typedef enum logic [3:0] {
    SelNone, SelMstatus, SelMtvec, SelMepc, SelMcause, SelMie, SelMscratch,
    SelMcycle, SelMcycleh, SelMinstret, SelMinstreth
  } csr_sel_e;

  localparam logic [3:0] CAUSE_MSI = 4'd3;
  localparam logic [3:0] CAUSE_MTI = 4'd7;
  localparam logic [3:0] CAUSE_MEI = 4'd11;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  function automatic logic [63:0] csr_apply(csr_op_e op, logic [63:0] old, logic [63:0] wd);
    case (op)
      CsrOpRw: return wd;
      CsrOpRs: return old | wd;
      CsrOpRc: return old & ~wd;
      default: return old;
    endcase
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit event counter with full or per-half software writes.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [63:0] wdata,
  output logic [63:0] value
);

  logic [63:0] cnt_q, cnt_d, sum;

  // A written half takes the data; an unwritten low half keeps counting, while an
  // unwritten high half holds when the low half is overwritten (its carry is stale).
  always_comb begin
    sum           = cnt_q + 64'(inc);
    cnt_d[31:0]   = wr_lo ? wdata[31:0] : sum[31:0];
    cnt_d[63:32]  = wr_hi ? wdata[63:32] : (wr_lo ? cnt_q[63:32] : sum[63:32]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign value = cnt_q;

endmodule

// File: rtl/csr_mmode.sv
// Machine-mode CSR file: CSR access, interrupt gating, trap entry and MRET redirect.
module csr_mmode
  import csr_mmode_pkg::*;
#(
  parameter int unsigned     XLEN         = 64,
  parameter logic [XLEN-1:0] MTVEC_RESET  = '0,
  parameter bit              HAS_MINSTRET = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     csr_addr,
  input  logic            csr_rena,
  input  logic            csr_wena,
  input  logic [1:0]      csr_op,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic            instret_inc,
  input  logic            exc_valid,
  input  logic [3:0]      exc_cause,
  input  logic [XLEN-1:0] exc_pc,
  input  logic            int_ack,
  input  logic [XLEN-1:0] int_pc,
  input  logic            mret_valid,
  input  logic            irq_ext,
  input  logic            irq_timer,
  input  logic            irq_soft,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  output logic            irq_req,
  output logic            trap_valid,
  output logic [XLEN-1:0] trap_pc,
  output logic [XLEN-1:0] diff_mstatus,
  output logic [XLEN-1:0] diff_mcause,
  output logic [XLEN-1:0] diff_mepc,
  output logic [XLEN-1:0] diff_mtvec,
  output logic [XLEN-1:0] diff_mie,
  output logic [XLEN-1:0] diff_mip,
  output logic [XLEN-1:0] diff_mscratch
);

  logic            mie_bit_q, mie_bit_d, mpie_q, mpie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [2:0]      mie_q, mie_d, sync1_q, sync2_q;  // {MEI, MTI, MSI}
  logic [63:0]     mcycle, minstret, cnt_wdata;
  logic            cyc_wr_lo, cyc_wr_hi, ins_wr_lo, ins_wr_hi;
  logic [XLEN-1:0] mstatus_rd, misa_rd, mie_rd, mip_rd, rdata, wval, base, tpc;
  csr_sel_e        sel;
  logic            addr_ok, read_only, illegal, wr_en, irq_int, int_take, trap_any;
  logic [2:0]      pend;
  logic [3:0]      irq_cause;

  function automatic logic [XLEN-1:0] irq_bits(logic [2:0] b);
    logic [XLEN-1:0] v;
    v     = '0;
    v[11] = b[2];
    v[7]  = b[1];
    v[3]  = b[0];
    return v;
  endfunction

  always_comb begin
    mstatus_rd                                = '0;
    mstatus_rd[MSTATUS_MIE]                   = mie_bit_q;
    mstatus_rd[MSTATUS_MPIE]                  = mpie_q;
    mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    misa_rd                                   = '0;
    misa_rd[XLEN-1 -: 2]                      = (XLEN == 64) ? 2'b10 : 2'b01;
    misa_rd[8]                                = 1'b1;
    mie_rd                                    = irq_bits(mie_q);
    mip_rd                                    = irq_bits(sync2_q);
  end

  always_comb begin
    rdata     = '0;
    sel       = SelNone;
    addr_ok   = 1'b1;
    read_only = 1'b0;
    case (csr_addr)
      CSR_MSTATUS:  begin rdata = mstatus_rd; sel = SelMstatus;  end
      CSR_MISA:     begin rdata = misa_rd;    read_only = 1'b1;  end
      CSR_MHARTID:  read_only = 1'b1;
      CSR_MTVEC:    begin rdata = mtvec_q;    sel = SelMtvec;    end
      CSR_MEPC:     begin rdata = mepc_q;     sel = SelMepc;     end
      CSR_MCAUSE:   begin rdata = mcause_q;   sel = SelMcause;   end
      CSR_MIE:      begin rdata = mie_rd;     sel = SelMie;      end
      CSR_MIP:      begin rdata = mip_rd;     read_only = 1'b1;  end
      CSR_MSCRATCH: begin rdata = mscratch_q; sel = SelMscratch; end
      CSR_MCYCLE:   begin rdata = mcycle[XLEN-1:0]; sel = SelMcycle; end
      CSR_MINSTRET: begin
        if (HAS_MINSTRET) begin rdata = minstret[XLEN-1:0]; sel = SelMinstret; end
        else read_only = 1'b1;
      end
      CSR_MCYCLEH: begin
        if (XLEN == 32) begin rdata = XLEN'(mcycle[63:32]); sel = SelMcycleh; end
        else addr_ok = 1'b0;
      end
      CSR_MINSTRETH: begin
        if (XLEN != 32) addr_ok = 1'b0;
        else if (HAS_MINSTRET) begin rdata = XLEN'(minstret[63:32]); sel = SelMinstreth; end
        else read_only = 1'b1;
      end
      default: addr_ok = 1'b0;
    endcase
  end

  assign illegal  = (csr_rena | csr_wena) & (~addr_ok | (csr_wena & read_only));
  assign pend     = mie_q & sync2_q;
  assign irq_int  = mie_bit_q & (|pend);
  assign int_take = int_ack & irq_int;
  assign trap_any = exc_valid | int_take | mret_valid;
  assign wr_en    = csr_wena & ~illegal & ~trap_any;
  assign wval     = XLEN'(csr_apply(csr_op_e'(csr_op), 64'(rdata), 64'(csr_wdata)));
  assign irq_cause = pend[2] ? CAUSE_MEI : (pend[0] ? CAUSE_MSI : CAUSE_MTI);
  assign base     = {mtvec_q[XLEN-1:2], 2'b00};

  always_comb begin
    tpc = '0;
    if (exc_valid)       tpc = base;
    else if (int_take)   tpc = base + (mtvec_q[0] ? XLEN'({irq_cause, 2'b00}) : '0);
    else if (mret_valid) tpc = mepc_q;
  end

  always_comb begin
    mie_bit_d  = mie_bit_q;
    mpie_d     = mpie_q;
    mtvec_d    = mtvec_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mie_d      = mie_q;
    mscratch_d = mscratch_q;
    if (exc_valid) begin
      mepc_d    = exc_pc & ~XLEN'(3);
      mcause_d  = XLEN'(exc_cause);
      mpie_d    = mie_bit_q;
      mie_bit_d = 1'b0;
    end else if (int_take) begin
      mepc_d           = int_pc & ~XLEN'(3);
      mcause_d         = XLEN'(irq_cause);
      mcause_d[XLEN-1] = 1'b1;
      mpie_d           = mie_bit_q;
      mie_bit_d        = 1'b0;
    end else if (mret_valid) begin
      mie_bit_d = mpie_q;
      mpie_d    = 1'b1;
    end else if (wr_en) begin
      case (sel)
        SelMstatus: begin
          mie_bit_d = wval[MSTATUS_MIE];
          mpie_d    = wval[MSTATUS_MPIE];
        end
        // Reserved MODE encodings 2/3 collapse to direct mode.
        SelMtvec:    mtvec_d    = {wval[XLEN-1:2], 1'b0, wval[0] & ~wval[1]};
        SelMepc:     mepc_d     = wval & ~XLEN'(3);
        SelMcause:   mcause_d   = wval;
        SelMie:      mie_d      = {wval[11], wval[7], wval[3]};
        SelMscratch: mscratch_d = wval;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mie_bit_q  <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RESET;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mie_q      <= '0;
      mscratch_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
    end else begin
      mie_bit_q  <= mie_bit_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mie_q      <= mie_d;
      mscratch_q <= mscratch_d;
      sync1_q    <= {irq_ext, irq_timer, irq_soft};
      sync2_q    <= sync1_q;
    end
  end

  assign cnt_wdata = (XLEN == 32) ? {2{wval[31:0]}} : 64'(wval);
  assign cyc_wr_lo = wr_en & (sel == SelMcycle);
  assign cyc_wr_hi = wr_en & ((sel == SelMcycleh) | ((XLEN == 64) && (sel == SelMcycle)));
  assign ins_wr_lo = wr_en & (sel == SelMinstret);
  assign ins_wr_hi = wr_en & ((sel == SelMinstreth) | ((XLEN == 64) && (sel == SelMinstret)));

  csr_counter64 u_mcycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .wr_lo (cyc_wr_lo),
    .wr_hi (cyc_wr_hi),
    .wdata (cnt_wdata),
    .value (mcycle)
  );

  if (HAS_MINSTRET) begin : g_minstret
    csr_counter64 u_minstret (
      .clk   (clk),
      .rst   (rst),
      .inc   (instret_inc),
      .wr_lo (ins_wr_lo),
      .wr_hi (ins_wr_hi),
      .wdata (cnt_wdata),
      .value (minstret)
    );
  end else begin : g_no_minstret
    assign minstret = '0;
  end

  assign csr_rdata     = rdata;
  assign csr_illegal   = ~rst & illegal;
  assign irq_req       = ~rst & irq_int;
  assign trap_valid    = ~rst & trap_any;
  assign trap_pc       = (~rst & trap_any) ? tpc : '0;
  assign diff_mstatus  = mstatus_rd;
  assign diff_mcause   = mcause_q;
  assign diff_mepc     = mepc_q;
  assign diff_mtvec    = mtvec_q;
  assign diff_mie      = mie_rd;
  assign diff_mip      = mip_rd;
  assign diff_mscratch = mscratch_q;

endmodule

// File: tb/tb_csr_mmode.sv
// Directed bench for csr_mmode (XLEN=64, MTVEC_RESET=0x8000_0000).
module tb_csr_mmode;
  import csr_mmode_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] csr_addr;
  logic        csr_rena, csr_wena, instret_inc, exc_valid, int_ack, mret_valid;
  logic [1:0]  csr_op;
  logic [63:0] csr_wdata, exc_pc, int_pc;
  logic [3:0]  exc_cause;
  logic        irq_ext, irq_timer, irq_soft;
  logic [63:0] csr_rdata, trap_pc;
  logic        csr_illegal, irq_req, trap_valid;
  logic [63:0] diff_mstatus, diff_mcause, diff_mepc, diff_mtvec, diff_mie, diff_mip;
  logic [63:0] diff_mscratch;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  csr_mmode #(
    .XLEN         (64),
    .MTVEC_RESET  (64'h8000_0000),
    .HAS_MINSTRET (1'b1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .csr_addr      (csr_addr),
    .csr_rena      (csr_rena),
    .csr_wena      (csr_wena),
    .csr_op        (csr_op),
    .csr_wdata     (csr_wdata),
    .instret_inc   (instret_inc),
    .exc_valid     (exc_valid),
    .exc_cause     (exc_cause),
    .exc_pc        (exc_pc),
    .int_ack       (int_ack),
    .int_pc        (int_pc),
    .mret_valid    (mret_valid),
    .irq_ext       (irq_ext),
    .irq_timer     (irq_timer),
    .irq_soft      (irq_soft),
    .csr_rdata     (csr_rdata),
    .csr_illegal   (csr_illegal),
    .irq_req       (irq_req),
    .trap_valid    (trap_valid),
    .trap_pc       (trap_pc),
    .diff_mstatus  (diff_mstatus),
    .diff_mcause   (diff_mcause),
    .diff_mepc     (diff_mepc),
    .diff_mtvec    (diff_mtvec),
    .diff_mie      (diff_mie),
    .diff_mip      (diff_mip),
    .diff_mscratch (diff_mscratch)
  );

  task automatic idle();
    csr_addr = '0; csr_rena = 0; csr_wena = 0; csr_op = CsrOpNone; csr_wdata = '0;
    instret_inc = 0; exc_valid = 0; exc_cause = '0; exc_pc = '0;
    int_ack = 0; int_pc = '0; mret_valid = 0;
  endtask

  task automatic csr_wr(input logic [11:0] addr, input logic [1:0] op, input logic [63:0] data);
    @(negedge clk);
    csr_addr = addr; csr_op = op; csr_wdata = data; csr_wena = 1;
    @(negedge clk);
    csr_wena = 0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1; idle(); irq_ext = 0; irq_timer = 0; irq_soft = 0;
    csr_addr = CSR_MTVEC; csr_rena = 1; exc_valid = 1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (csr_rdata !== 64'h8000_0000) begin failures++;
      $display("FAIL reset_mtvec_read got=%h want=%h", csr_rdata, 64'h8000_0000); end
    checks++; if (diff_mtvec !== 64'h8000_0000) begin failures++;
      $display("FAIL reset_diff_mtvec got=%h want=%h", diff_mtvec, 64'h8000_0000); end
    checks++; if (diff_mstatus !== 64'h1800) begin failures++;
      $display("FAIL reset_mstatus got=%h want=%h", diff_mstatus, 64'h1800); end
    checks++; if (trap_valid !== 1'b0) begin failures++;
      $display("FAIL reset_trap_valid got=%b want=0", trap_valid); end
    csr_addr = 12'h7FF; #1;
    checks++; if (csr_illegal !== 1'b0) begin failures++;
      $display("FAIL reset_illegal got=%b want=0", csr_illegal); end
    @(negedge clk);
    exc_valid = 0; csr_addr = CSR_MCYCLE; rst = 0; #1;
    checks++; if (csr_rdata !== 64'd0) begin failures++;
      $display("FAIL mcycle_start got=%h want=0", csr_rdata); end
    @(negedge clk); #1;
    checks++; if (csr_rdata !== 64'd1) begin failures++;
      $display("FAIL mcycle_first_inc got=%h want=1", csr_rdata); end
  endtask

  task automatic test_irq_timer();
    csr_wr(CSR_MSTATUS, CsrOpRs, 64'h8);
    csr_wr(CSR_MIE, CsrOpRs, 64'h80);
    csr_wr(CSR_MTVEC, CsrOpRw, 64'h201);
    checks++; if (diff_mstatus !== 64'h1808) begin failures++;
      $display("FAIL rs_mstatus got=%h want=%h", diff_mstatus, 64'h1808); end
    checks++; if (diff_mie !== 64'h80) begin failures++;
      $display("FAIL rs_mie got=%h want=%h", diff_mie, 64'h80); end
    irq_timer = 1;
    @(negedge clk); #1;
    checks++; if (irq_req !== 1'b0) begin failures++;
      $display("FAIL irq_sync_stage1 got=%b want=0", irq_req); end
    @(negedge clk); #1;
    checks++; if (irq_req !== 1'b1) begin failures++;
      $display("FAIL irq_sync_stage2 got=%b want=1", irq_req); end
    checks++; if (diff_mip !== 64'h80) begin failures++;
      $display("FAIL mip_timer got=%h want=%h", diff_mip, 64'h80); end
    int_ack = 1; int_pc = 64'h100; #1;
    checks++; if (trap_valid !== 1'b1 || trap_pc !== 64'h21C) begin failures++;
      $display("FAIL int_vectored got=%b/%h want=1/%h", trap_valid, trap_pc, 64'h21C); end
    @(negedge clk); int_ack = 0; #1;
    checks++; if (diff_mepc !== 64'h100) begin failures++;
      $display("FAIL int_mepc got=%h want=%h", diff_mepc, 64'h100); end
    checks++; if (diff_mcause !== 64'h8000_0000_0000_0007) begin failures++;
      $display("FAIL int_mcause got=%h want=%h", diff_mcause, 64'h8000_0000_0000_0007); end
    checks++; if (diff_mstatus !== 64'h1880 || irq_req !== 1'b0) begin failures++;
      $display("FAIL int_mstatus got=%h/%b want=%h/0", diff_mstatus, irq_req, 64'h1880); end
    int_ack = 1; int_pc = 64'h300; #1;
    checks++; if (trap_valid !== 1'b0) begin failures++;
      $display("FAIL int_ack_no_irq got=%b want=0", trap_valid); end
    @(negedge clk); int_ack = 0; #1;
    checks++; if (diff_mepc !== 64'h100) begin failures++;
      $display("FAIL int_ack_no_irq_mepc got=%h want=%h", diff_mepc, 64'h100); end
  endtask

  task automatic test_mret();
    mret_valid = 1; #1;
    checks++; if (trap_valid !== 1'b1 || trap_pc !== 64'h100) begin failures++;
      $display("FAIL mret_pc got=%b/%h want=1/%h", trap_valid, trap_pc, 64'h100); end
    @(negedge clk); mret_valid = 0; #1;
    checks++; if (diff_mstatus !== 64'h1888) begin failures++;
      $display("FAIL mret_mstatus got=%h want=%h", diff_mstatus, 64'h1888); end
    checks++; if (irq_req !== 1'b1) begin failures++;
      $display("FAIL mret_irq_reenabled got=%b want=1", irq_req); end
  endtask

  task automatic test_exc_priority();
    csr_wr(CSR_MSCRATCH, CsrOpRw, 64'h55);
    exc_valid = 1; exc_cause = 4'd2; exc_pc = 64'h40;
    int_ack = 1; int_pc = 64'h500; mret_valid = 1;
    csr_addr = CSR_MSCRATCH; csr_op = CsrOpRw; csr_wdata = 64'hAA; csr_wena = 1; #1;
    checks++; if (trap_valid !== 1'b1 || trap_pc !== 64'h200) begin failures++;
      $display("FAIL exc_trap_pc got=%b/%h want=1/%h", trap_valid, trap_pc, 64'h200); end
    @(negedge clk); idle(); #1;
    checks++; if (diff_mepc !== 64'h40 || diff_mcause !== 64'd2) begin failures++;
      $display("FAIL exc_mepc_mcause got=%h/%h want=40/2", diff_mepc, diff_mcause); end
    checks++; if (diff_mscratch !== 64'h55) begin failures++;
      $display("FAIL exc_drops_csr_write got=%h want=%h", diff_mscratch, 64'h55); end
    checks++; if (diff_mstatus !== 64'h1880) begin failures++;
      $display("FAIL exc_mstatus got=%h want=%h", diff_mstatus, 64'h1880); end
  endtask

  task automatic test_fields();
    csr_wr(CSR_MTVEC, CsrOpRw, 64'h303);
    checks++; if (diff_mtvec !== 64'h300) begin failures++;
      $display("FAIL mtvec_warl got=%h want=%h", diff_mtvec, 64'h300); end
    csr_wr(CSR_MEPC, CsrOpRw, 64'h47);
    checks++; if (diff_mepc !== 64'h44) begin failures++;
      $display("FAIL mepc_align got=%h want=%h", diff_mepc, 64'h44); end
    csr_wr(CSR_MIE, CsrOpRw, '1);
    checks++; if (diff_mie !== 64'h888) begin failures++;
      $display("FAIL mie_mask got=%h want=%h", diff_mie, 64'h888); end
    csr_wr(CSR_MIE, CsrOpRc, 64'h80);
    checks++; if (diff_mie !== 64'h808) begin failures++;
      $display("FAIL mie_rc got=%h want=%h", diff_mie, 64'h808); end
    csr_wr(CSR_MIE, CsrOpRs, 64'h80);
    csr_wr(CSR_MSTATUS, CsrOpRw, '1);
    checks++; if (diff_mstatus !== 64'h1888 || diff_mie !== 64'h888) begin failures++;
      $display("FAIL mstatus_rw got=%h/%h want=1888/888", diff_mstatus, diff_mie); end
    csr_addr = CSR_MCAUSE; csr_rena = 1; #1;
    checks++; if (csr_rdata !== 64'd2) begin failures++;
      $display("FAIL mcause_read got=%h want=2", csr_rdata); end
    csr_rena = 0;
  endtask

  task automatic test_irq_priority();
    csr_wr(CSR_MTVEC, CsrOpRw, 64'h201);
    irq_ext = 1; irq_soft = 1;
    repeat (3) @(negedge clk);
    int_ack = 1; int_pc = 64'h600; #1;
    checks++; if (trap_valid !== 1'b1 || trap_pc !== 64'h22C) begin failures++;
      $display("FAIL mei_first got=%b/%h want=1/%h", trap_valid, trap_pc, 64'h22C); end
    @(negedge clk); int_ack = 0; #1;
    checks++; if (diff_mcause !== 64'h8000_0000_0000_000B) begin failures++;
      $display("FAIL mei_mcause got=%h want=%h", diff_mcause, 64'h8000_0000_0000_000B); end
    mret_valid = 1;
    @(negedge clk); mret_valid = 0; irq_ext = 0;
    repeat (3) @(negedge clk);
    int_ack = 1; #1;
    checks++; if (trap_valid !== 1'b1 || trap_pc !== 64'h20C) begin failures++;
      $display("FAIL msi_over_mti got=%b/%h want=1/%h", trap_valid, trap_pc, 64'h20C); end
    @(negedge clk); int_ack = 0; irq_soft = 0; irq_timer = 0; #1;
    checks++; if (diff_mcause !== 64'h8000_0000_0000_0003) begin failures++;
      $display("FAIL msi_mcause got=%h want=%h", diff_mcause, 64'h8000_0000_0000_0003); end
  endtask

  task automatic test_counters();
    csr_wr(CSR_MCYCLE, CsrOpRw, '1);
    checks++; if (csr_rdata !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++;
      $display("FAIL mcycle_write got=%h want=all-ones", csr_rdata); end
    @(negedge clk); #1;
    checks++; if (csr_rdata !== 64'd0) begin failures++;
      $display("FAIL mcycle_wrap got=%h want=0", csr_rdata); end
    csr_wr(CSR_MINSTRET, CsrOpRw, 64'd0);
    instret_inc = 1;
    repeat (3) @(negedge clk);
    instret_inc = 0; #1;
    checks++; if (csr_rdata !== 64'd3) begin failures++;
      $display("FAIL minstret_count got=%h want=3", csr_rdata); end
    @(negedge clk);
    csr_op = CsrOpRw; csr_wdata = 64'd10; csr_wena = 1; instret_inc = 1;
    @(negedge clk);
    csr_wena = 0; instret_inc = 0; #1;
    checks++; if (csr_rdata !== 64'd10) begin failures++;
      $display("FAIL minstret_write_wins got=%h want=10", csr_rdata); end
  endtask

  task automatic test_illegal();
    repeat (3) @(negedge clk);
    csr_addr = CSR_MISA; csr_rena = 1; #1;
    checks++; if (csr_illegal !== 1'b0 || csr_rdata !== 64'h8000_0000_0000_0100) begin
      failures++;
      $display("FAIL misa_read got=%b/%h want=0/%h", csr_illegal, csr_rdata,
               64'h8000_0000_0000_0100); end
    csr_addr = CSR_MHARTID; #1;
    checks++; if (csr_illegal !== 1'b0 || csr_rdata !== 64'd0) begin failures++;
      $display("FAIL mhartid_read got=%b/%h want=0/0", csr_illegal, csr_rdata); end
    @(negedge clk);
    csr_addr = CSR_MISA; csr_op = CsrOpRw; csr_wdata = 64'd0; csr_wena = 1; #1;
    checks++; if (csr_illegal !== 1'b1) begin failures++;
      $display("FAIL misa_write_illegal got=%b want=1", csr_illegal); end
    @(negedge clk); csr_wena = 0; #1;
    checks++; if (csr_rdata !== 64'h8000_0000_0000_0100) begin failures++;
      $display("FAIL misa_unchanged got=%h want=%h", csr_rdata, 64'h8000_0000_0000_0100); end
    csr_addr = 12'h7FF; csr_wdata = 64'd0; csr_wena = 1; #1;
    checks++; if (csr_illegal !== 1'b1 || csr_rdata !== 64'd0) begin failures++;
      $display("FAIL unimpl_illegal got=%b/%h want=1/0", csr_illegal, csr_rdata); end
    @(negedge clk);
    csr_addr = CSR_MIP; csr_wdata = '1; #1;
    checks++; if (csr_illegal !== 1'b1) begin failures++;
      $display("FAIL mip_write_illegal got=%b want=1", csr_illegal); end
    @(negedge clk); idle(); #1;
    checks++; if (diff_mip !== 64'd0 || diff_mscratch !== 64'h55) begin failures++;
      $display("FAIL illegal_no_state_change got=%h/%h want=0/55", diff_mip, diff_mscratch);
    end
  endtask

  initial begin
    test_reset();
    test_irq_timer();
    test_mret();
    test_exc_priority();
    test_fields();
    test_irq_priority();
    test_counters();
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
